perf_counter_bank: RTL and testbench

Synthesizable, parametrised event-counter bank that moves pipeline performance accounting into hardware. It sits beside the processor core and counts per-cycle event strobes: retired instructions, I-cache requests/hits, D-cache requests/hits and cycles. It freezes all counts when the core halts, and exposes each count through a registered read port so software or a debug bridge can sample it without stopping the clock.

---
 rtl/perf_pkg.sv | 17 +
 rtl/perf_counter_bank_if.sv | 31 +++
 rtl/perf_counter.sv | 47 ++++
 rtl/perf_counter_bank.sv | 96 +++++++++
 tb/tb_perf_counter_bank.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/perf_pkg.sv
// Shared definitions for the performance counter bank: FSM encoding and the
// event channel map the core wires into event_vec.
package perf_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRun    = 2'd1,
    StFrozen = 2'd2
  } state_e;

  localparam int unsigned EV_RETIRE = 0;
  localparam int unsigned EV_ICREQ  = 1;
  localparam int unsigned EV_ICHIT  = 2;
  localparam int unsigned EV_DCREQ  = 3;
  localparam int unsigned EV_DCHIT  = 4;

endpackage

// File: rtl/perf_counter_bank_if.sv
// Control, event and read-port bundle between the core/debug side and the counter bank.
interface perf_counter_bank_if #(
    parameter int unsigned NUM_EVENTS = 5,
    parameter int unsigned CNT_WIDTH  = 32,
    parameter int unsigned SEL_WIDTH  = 4
);

    logic                  start;
    logic                  halt;
    logic                  clr;
    logic [NUM_EVENTS-1:0] event_vec;
    logic                  rd_req;
    logic [SEL_WIDTH-1:0]  rd_sel;
    logic                  rd_valid;
    logic [CNT_WIDTH-1:0]  rd_data;
    logic                  rd_err;
    logic [NUM_EVENTS:0]   ovf;
    logic                  running;
    logic                  halted;

    modport master (
        output start, halt, clr, event_vec, rd_req, rd_sel,
        input  rd_valid, rd_data, rd_err, ovf, running, halted
    );

    modport slave (
        input  start, halt, clr, event_vec, rd_req, rd_sel,
        output rd_valid, rd_data, rd_err, ovf, running, halted
    );

endinterface

// File: rtl/perf_counter.sv
// Single event counter with synchronous clear, optional saturation and a sticky
// overflow flag set by any increment from all-ones.
module perf_counter #(
    parameter int unsigned CNT_WIDTH = 32,
    parameter int unsigned SATURATE  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] cnt,
    output logic                 ovf
);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clr) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (inc) begin
            if (&cnt_q) begin
                ovf_d = 1'b1;
                cnt_d = (SATURATE != 0) ? cnt_q : '0;
            end else begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt = cnt_q;
    assign ovf = ovf_q;

endmodule

// File: rtl/perf_counter_bank.sv
// Event counter bank: NUM_EVENTS event counters plus a cycle counter, gated by an
// IDLE/RUN/FROZEN FSM, with a registered one-cycle-latency read port.
module perf_counter_bank
    import perf_pkg::*;
#(
    parameter int unsigned NUM_EVENTS = 5,
    parameter int unsigned CNT_WIDTH  = 32,
    parameter int unsigned SATURATE   = 1,
    parameter int unsigned SEL_WIDTH  = 4
) (
    input logic                clk,
    input logic                rst,
    perf_counter_bank_if.slave bus
);

    state_e state_q, state_d;

    logic                 cnt_en;
    logic [NUM_EVENTS:0]  inc;
    logic [NUM_EVENTS:0]  ovf_vec;
    logic [CNT_WIDTH-1:0] cnt [NUM_EVENTS+1];

    logic [CNT_WIDTH-1:0] sel_data;
    logic                 sel_err;

    logic                 rd_valid_q;
    logic [CNT_WIDTH-1:0] rd_data_q;
    logic                 rd_err_q;
    logic                 running_q;
    logic                 halted_q;

    // The halt cycle still counts; clr wins over any event in the same cycle.
    assign cnt_en = (state_q == StRun) && !bus.clr;
    assign inc    = {cnt_en, bus.event_vec & {NUM_EVENTS{cnt_en}}};

    for (genvar i = 0; i <= NUM_EVENTS; i++) begin : g_cnt
        perf_counter #(
            .CNT_WIDTH (CNT_WIDTH),
            .SATURATE  (SATURATE)
        ) u_cnt (
            .clk (clk),
            .rst (rst),
            .inc (inc[i]),
            .clr (bus.clr),
            .cnt (cnt[i]),
            .ovf (ovf_vec[i])
        );
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (bus.start) state_d = StRun;
            StRun: begin
                if (bus.clr && bus.halt) state_d = StIdle;
                else if (bus.halt)       state_d = StFrozen;
            end
            StFrozen: if (bus.clr) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i <= NUM_EVENTS; i++) begin
            if (bus.rd_sel == SEL_WIDTH'(i)) sel_data = cnt[i];
        end
        sel_err = bus.rd_sel > SEL_WIDTH'(NUM_EVENTS);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_err_q   <= 1'b0;
            running_q  <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_valid_q <= bus.rd_req;
            rd_err_q   <= bus.rd_req && sel_err;
            if (bus.rd_req) rd_data_q <= sel_data;
            running_q  <= (state_d == StRun);
            halted_q   <= (state_d == StFrozen);
        end
    end

    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_err   = rd_err_q;
    assign bus.ovf      = ovf_vec;
    assign bus.running  = running_q;
    assign bus.halted   = halted_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench for perf_counter_bank: one 32-bit saturating bank and two 8-bit
// banks (saturating / wrapping) driven by the same stimulus.
module tb_perf_counter_bank;

    logic       clk = 1'b0;
    logic       rst, start, halt, clr, rd_req;
    logic [4:0] event_vec;
    logic [3:0] rd_sel;
    int         n_chk = 0;
    int         n_bad = 0;
    int         exp_d [7] = '{0, 0, 0, 0, 4, 5, 0};

    always #5 clk = ~clk;

    perf_counter_bank_if #(.NUM_EVENTS(5), .CNT_WIDTH(32), .SEL_WIDTH(4)) if_a ();
    perf_counter_bank_if #(.NUM_EVENTS(5), .CNT_WIDTH(8),  .SEL_WIDTH(4)) if_b ();
    perf_counter_bank_if #(.NUM_EVENTS(5), .CNT_WIDTH(8),  .SEL_WIDTH(4)) if_c ();

    assign if_a.start = start;  assign if_a.halt = halt;     assign if_a.clr = clr;
    assign if_a.event_vec = event_vec; assign if_a.rd_req = rd_req; assign if_a.rd_sel = rd_sel;
    assign if_b.start = start;  assign if_b.halt = halt;     assign if_b.clr = clr;
    assign if_b.event_vec = event_vec; assign if_b.rd_req = rd_req; assign if_b.rd_sel = rd_sel;
    assign if_c.start = start;  assign if_c.halt = halt;     assign if_c.clr = clr;
    assign if_c.event_vec = event_vec; assign if_c.rd_req = rd_req; assign if_c.rd_sel = rd_sel;

    perf_counter_bank #(.NUM_EVENTS(5), .CNT_WIDTH(32), .SATURATE(1), .SEL_WIDTH(4)) u_dut_a (
        .clk (clk), .rst (rst), .bus (if_a.slave)
    );
    perf_counter_bank #(.NUM_EVENTS(5), .CNT_WIDTH(8), .SATURATE(1), .SEL_WIDTH(4)) u_dut_b (
        .clk (clk), .rst (rst), .bus (if_b.slave)
    );
    perf_counter_bank #(.NUM_EVENTS(5), .CNT_WIDTH(8), .SATURATE(0), .SEL_WIDTH(4)) u_dut_c (
        .clk (clk), .rst (rst), .bus (if_c.slave)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [3:0] sel);
        rd_req = 1'b1;
        rd_sel = sel;
        tick();
        rd_req = 1'b0;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; halt = 1'b0; clr = 1'b0;
        rd_req = 1'b0; rd_sel = '0; event_vec = '0;
        tick(); tick();
        chk("rst_running", if_a.running, 0);
        chk("rst_halted", if_a.halted, 0);
        chk("rst_rd_valid", if_a.rd_valid, 0);
        chk("rst_rd_data", if_a.rd_data, 0);
        chk("rst_ovf", if_a.ovf, 0);

        // Events while IDLE must not count.
        rst = 1'b1;
        event_vec = 5'h1F;
        repeat (10) tick();
        event_vec = '0;
        for (int s = 0; s <= 5; s++) begin
            rd(4'(s));
            chk("idle_valid", if_a.rd_valid, 1);
            chk("idle_data", if_a.rd_data, 0);
        end
        chk("idle_running", if_a.running, 0);

        start = 1'b1; tick(); start = 1'b0;
        chk("start_running", if_a.running, 1);
        for (int i = 0; i < 7; i++) begin
            event_vec = 5'h01;
            halt = (i == 6);
            tick();
        end
        event_vec = '0; halt = 1'b0;
        chk("halt_halted", if_a.halted, 1);
        chk("halt_running", if_a.running, 0);
        event_vec = 5'h1F;
        repeat (5) tick();
        event_vec = '0;
        rd(0); chk("frozen_ch0", if_a.rd_data, 7);
        rd(5); chk("frozen_cycle", if_a.rd_data, 7);
        rd(1); chk("frozen_ch1", if_a.rd_data, 0);

        clr = 1'b1; tick(); clr = 1'b0;
        chk("clr_frozen_halted", if_a.halted, 0);
        chk("clr_frozen_running", if_a.running, 0);
        rd(0); chk("clr_frozen_ch0", if_a.rd_data, 0);

        // 300 events on ch2: 32-bit counts, 8-bit saturates or wraps.
        start = 1'b1; tick(); start = 1'b0;
        event_vec = 5'h04;
        repeat (300) tick();
        event_vec = '0;
        rd(2);
        chk("sat32_ch2", if_a.rd_data, 300);
        chk("sat8_ch2", if_b.rd_data, 8'hFF);
        chk("wrap8_ch2", if_c.rd_data, 44);
        chk("sat32_ovf2", if_a.ovf[2], 0);
        chk("sat8_ovf2", if_b.ovf[2], 1);
        chk("wrap8_ovf2", if_c.ovf[2], 1);

        clr = 1'b1; tick(); clr = 1'b0;
        chk("clr_run_running", if_a.running, 1);
        chk("clr_run_ovf", if_b.ovf, 0);
        event_vec = 5'h02;
        repeat (12) tick();
        event_vec = '0;
        rd(1); chk("ch1_12", if_a.rd_data, 12);

        clr = 1'b1; halt = 1'b1; event_vec = 5'h02;
        tick();
        clr = 1'b0; halt = 1'b0; event_vec = '0;
        chk("clrhalt_running", if_a.running, 0);
        chk("clrhalt_halted", if_a.halted, 0);
        rd(1); chk("clrhalt_ch1", if_a.rd_data, 0);
        rd(5); chk("clrhalt_cycle", if_a.rd_data, 0);

        // Back-to-back sweep; each read sees the count before that cycle's update.
        start = 1'b1; tick(); start = 1'b0;
        event_vec = 5'h11;
        rd_req = 1'b1;
        for (int s = 0; s <= 6; s++) begin
            rd_sel = 4'(s);
            tick();
            chk("sweep_valid", if_a.rd_valid, 1);
            chk("sweep_data", if_a.rd_data, 64'(exp_d[s]));
            chk("sweep_err", if_a.rd_err, (s == 6) ? 1 : 0);
        end
        rd_req = 1'b0;
        event_vec = '0;
        rd(4); chk("sweep_ch4", if_a.rd_data, 7);
        tick();
        chk("hold_valid", if_a.rd_valid, 0);
        chk("hold_data", if_a.rd_data, 7);
        chk("hold_err", if_a.rd_err, 0);

        halt = 1'b1; tick(); halt = 1'b0;
        chk("frz2_halted", if_a.halted, 1);
        rd_req = 1'b1; rd_sel = 4'd0; rst = 1'b0;
        tick();
        rd_req = 1'b0;
        chk("rstfrz_valid", if_a.rd_valid, 0);
        chk("rstfrz_data", if_a.rd_data, 0);
        chk("rstfrz_halted", if_a.halted, 0);
        chk("rstfrz_running", if_a.running, 0);
        chk("rstfrz_ovf", if_b.ovf, 0);
        rst = 1'b1;
        rd(0); chk("rstfrz_ch0", if_a.rd_data, 0);
        rd(5); chk("rstfrz_cycle", if_a.rd_data, 0);
        chk("rstfrz_idle", if_a.running, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
